// File: rtl/prng_code_gen.sv
// Fibonacci-LFSR secret-code generator with a req/valid/ack handshake and runtime reseed.
// Optional macro PRNG_CODE_DISTINCT_EN: reject symbols that repeat an already-written slot.
module prng_code_gen #(
  parameter int                LFSR_W  = 12,
  parameter logic [LFSR_W-1:0] TAPS    = 12'hE08,
  parameter logic [LFSR_W-1:0] SEED    = 12'h3D5,
  parameter int                SYM_W   = 3,
  parameter int                NUM_SYM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     ack,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_in,
  output logic [NUM_SYM*SYM_W-1:0] code,
  output logic                     valid,
  output logic                     busy
);
  localparam int IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int BIT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DONE} fsm_t;

  fsm_t              fsm;
  logic [LFSR_W-1:0] state;
  logic [SYM_W-1:0]  sym;
  logic [IDX_W-1:0]  idx;
  logic [BIT_W-1:0]  bit_cnt;
  logic              fb;
  logic [SYM_W-1:0]  sym_next;
  logic              sym_done;
  logic              last_slot;
  logic              dup;

  assign fb        = ^(state & TAPS);
  assign sym_next  = SYM_W'({sym, fb});
  assign sym_done  = (bit_cnt == BIT_W'(SYM_W - 1));
  assign last_slot = (idx == IDX_W'(NUM_SYM - 1));

`ifdef PRNG_CODE_DISTINCT_EN
  if (NUM_SYM > 2**SYM_W) begin : g_bad_cfg
    $error("prng_code_gen: NUM_SYM exceeds the number of distinct symbols");
  end

  // A finished symbol is a duplicate if it equals any slot already written.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if ((i < 32'(idx)) && (code[i*SYM_W +: SYM_W] == sym_next)) dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      state   <= (rst || (seed_in == '0)) ? SEED : seed_in;
      fsm     <= IDLE;
      code    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      sym     <= '0;
      bit_cnt <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            fsm     <= GEN;
            busy    <= 1'b1;
            code    <= '0;
            idx     <= '0;
            sym     <= '0;
            bit_cnt <= '0;
          end
        end
        GEN: begin
          // An all-zero state would stick forever; recover instead of stepping.
          if (state == '0) begin
            state <= SEED;
          end else begin
            state <= {state[LFSR_W-2:0], fb};
            if (sym_done) begin
              bit_cnt <= '0;
              sym     <= '0;
              if (!dup) begin
                code[idx*SYM_W +: SYM_W] <= sym_next;
                if (last_slot) begin
                  fsm   <= DONE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sym     <= sym_next;
            end
          end
        end
        DONE: begin
          if (ack) begin
            fsm   <= IDLE;
            valid <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prng_code_gen.sv
// Self-checking bench for prng_code_gen: directed and randomized handshakes against an arithmetic LFSR model.
module tb_prng_code_gen;
  localparam logic [11:0] SEED_M = 12'h3D5;
  localparam logic [11:0] TAPS_M = 12'hE08;

  logic        clk = 1'b0;
  logic        rst, req, ack, seed_load;
  logic [11:0] seed_in;
  logic [11:0] code;
  logic        valid, busy;
  logic        req2, ack2;
  logic [0:0]  code2;
  logic        valid2, busy2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] mstate;

  always #5 clk = ~clk;

  prng_code_gen dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .seed_load(seed_load),
    .seed_in(seed_in), .code(code), .valid(valid), .busy(busy)
  );

  prng_code_gen #(.SYM_W(1), .NUM_SYM(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .ack(ack2), .seed_load(1'b0),
    .seed_in(12'h000), .code(code2), .valid(valid2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Shift left by one, drop the top bit, append the parity of the tapped bits.
  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    int v;
    int p;
    if (s == 12'h000) return SEED_M;
    v = int'(s);
    p = $countones(s & TAPS_M) % 2;
    return 12'(((v * 2) % 4096) + p);
  endfunction

  function automatic void model_code(inout logic [11:0] s, output logic [11:0] c, output int rej);
    int syms[$];
    int sy;
    int val;
    bit seen;
    val = 0;
    rej = 0;
    while (syms.size() < 4) begin
      sy = 0;
      for (int b = 0; b < 3; b++) begin
        s  = lfsr_next(s);
        sy = sy * 2 + int'(s[0]);
      end
      seen = 1'b0;
`ifdef PRNG_CODE_DISTINCT_EN
      foreach (syms[j]) if (syms[j] == sy) seen = 1'b1;
`endif
      if (seen) rej++;
      else syms.push_back(sy);
    end
    foreach (syms[i]) val += syms[i] * (8 ** i);
    c = 12'(val);
  endfunction

  task automatic run_code(input string tag);
    logic [11:0] exp_code;
    int          rej;
    int          lat;
    int          hold;
    bit          distinct;
    model_code(mstate, exp_code, rej);
    req = 1'b1;
    cyc();
    check({tag, "_busy_start"}, 64'(busy), 64'(1));
    check({tag, "_valid_start"}, 64'(valid), 64'(0));
    lat = 0;
    while (!valid && lat < 200) begin
      req = 1'($urandom_range(0, 1));
      cyc();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(12 + 3 * rej));
    check({tag, "_code"}, 64'(code), 64'(exp_code));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
    distinct = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (code[i*3 +: 3] == code[j*3 +: 3]) distinct = 1'b0;
`ifdef PRNG_CODE_DISTINCT_EN
    check({tag, "_distinct"}, 64'(distinct), 64'(1));
`endif
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      req = 1'($urandom_range(0, 1));
      cyc();
      check({tag, "_valid_hold"}, 64'(valid), 64'(1));
      check({tag, "_code_hold"}, 64'(code), 64'(exp_code));
    end
    ack = 1'b1;
    req = 1'($urandom_range(0, 1));
    cyc();
    ack = 1'b0;
    req = 1'b0;
    check({tag, "_valid_ack"}, 64'(valid), 64'(0));
    check({tag, "_busy_ack"}, 64'(busy), 64'(0));
    cyc();
    check({tag, "_no_second"}, 64'(busy), 64'(0));
  endtask

  task automatic load_seed(input logic [11:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    mstate    = (s == 12'h000) ? SEED_M : s;
    check("seed_state", 64'(dut.state), 64'(mstate));
  endtask

  initial begin
    int          seen;
    int          period;
    int          guard;
    logic [11:0] ms;
    logic [11:0] rs;

    rst = 1'b1; req = 1'b0; ack = 1'b0; seed_load = 1'b0; seed_in = '0;
    req2 = 1'b0; ack2 = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    mstate = SEED_M;
    check("rst_code", 64'(code), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(dut.state), 64'(SEED_M));
    check("rst_busy2", 64'(busy2), 64'(0));

    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("idle_ack_valid", 64'(valid), 64'(0));
    check("idle_ack_busy", 64'(busy), 64'(0));
    check("idle_ack_state", 64'(dut.state), 64'(SEED_M));

    run_code("single");

    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        rs = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
        load_seed(rs);
      end
      repeat ($urandom_range(0, 3)) cyc();
      run_code("random");
    end

    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (7) cyc();
    seed_load = 1'b1;
    seed_in   = 12'h000;
    cyc();
    seed_load = 1'b0;
    mstate    = SEED_M;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_valid", 64'(valid), 64'(0));
    check("abort_code", 64'(code), 64'(0));
    check("abort_state", 64'(dut.state), 64'(SEED_M));
    run_code("after_abort");

    load_seed(12'h001);
    run_code("seed001");

    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mstate = SEED_M;
    check("midrst_code", 64'(code), 64'(0));
    check("midrst_valid", 64'(valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_state", 64'(dut.state), 64'(SEED_M));
    run_code("after_rst");

`ifdef PRNG_CODE_DISTINCT_EN
    for (int s = 1; s <= 255; s++) begin
      load_seed(12'(s));
      run_code("sweep");
    end
`endif

    req2 = 1'b1;
    ack2 = 1'b1;
    seen = 0;
    period = 0;
    guard = 0;
    ms = SEED_M;
    while (seen < 4096 && guard < 13000) begin
      cyc();
      guard++;
      if (valid2) begin
        seen++;
        ms = lfsr_next(ms);
        check("period_bit", 64'(code2), 64'(ms[0]));
        check("period_state", 64'(dut2.state), 64'(ms));
        if (period == 0 && dut2.state == SEED_M) period = seen;
      end
    end
    req2 = 1'b0;
    ack2 = 1'b0;
    check("period_codes", 64'(seen), 64'(4096));
    check("period_len", 64'(period), 64'(4095));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
